morse_press_classifier: RTL

Converts the raw push-button level from a player's key into single-cycle Morse symbol strobes: `ld_dot`, `ld_line` and an end-of-letter `ld_gap`. It sits directly upstream of the player answer-checking logic, which concatenates these strobes into its 10-bit Morse register. Internally it synchronises and debounces the key, measures the press length with a saturating counter, and classifies the press on release.

---
 rtl/morse_pkg.sv | 37 +++
 rtl/key_debouncer.sv | 68 ++++++
 rtl/morse_press_classifier.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key front end: symbol codes (also used by
// the player answer-checking stage), classifier FSM states and the press
// classification rule.
package morse_pkg;

  // Symbol codes shared with the player stage.
  typedef enum logic [1:0] {
    MORSE_NONE = 2'b00,
    MORSE_DOT  = 2'b01,
    MORSE_LINE = 2'b11
  } morse_sym_e;

  // Classifier FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESS     = 2'b01,
    GAP       = 2'b10,
    GAP_ABORT = 2'b11
  } press_state_e;

  // Map a completed press length onto a symbol. A press that reached the
  // abort length (the counter saturates there) yields no symbol.
  function automatic morse_sym_e classify_press(
    input int unsigned count,
    input int unsigned dot_max,
    input int unsigned abort_max
  );
    if (count >= abort_max) begin
      return MORSE_NONE;
    end else if (count < dot_max) begin
      return MORSE_DOT;
    end else begin
      return MORSE_LINE;
    end
  endfunction

endpackage : morse_pkg

// File: rtl/key_debouncer.sv
// Key input conditioning: a 2-flop synchroniser followed by a stability
// filter. The output level only moves after the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// Optional filter: `MORSE_DEBOUNCE_EN. When it is not defined the output is
// the synchroniser output directly and DEBOUNCE_CYCLES has no effect.
module key_debouncer
  import morse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic user_input,
  output logic key
);

  logic sync_meta;
  logic sync_q;

  // A zero-length filter window has no meaning; reject it at elaboration.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_debouncer: DEBOUNCE_CYCLES must be at least 1");
  end

  // Two-flop synchroniser for the asynchronous key level.
  // NOTE: the synchroniser flops are reset too, so a key held through reset
  // is seen as a fresh rising edge once reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= user_input;
      sync_q    <= sync_meta;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  // The count runs 0..DEBOUNCE_CYCLES-1, so this width is sufficient.
  localparam int unsigned CNT_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] stable_cnt;
  logic             key_q;

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample that agrees with the current level restarts the window.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_q      <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_q == key_q) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      key_q      <= sync_q;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign key = key_q;
`else
  assign key = sync_q;
`endif

endmodule : key_debouncer

// File: rtl/morse_press_classifier.sv
// Turns a raw push-button level into one-cycle Morse strobes: ld_dot and
// ld_line on release of a press, ld_gap once the key has stayed released
// long enough to end the letter. Over-long presses are discarded.
// Optional debounce filter in the key path: `MORSE_DEBOUNCE_EN.
module morse_press_classifier
  import morse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DOT_MAX_CYCLES  = 12500000,
  parameter int unsigned ABORT_CYCLES    = 100000000,
  parameter int unsigned GAP_CYCLES      = 37500000
) (
  input  logic clock,
  input  logic reset,
  input  logic user_input,
  output logic ld_dot,
  output logic ld_line,
  output logic ld_gap,
  output logic pressing
);

  localparam int unsigned PRESS_W = $clog2(ABORT_CYCLES + 1);
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

  localparam logic [PRESS_W-1:0] PRESS_MAX = PRESS_W'(ABORT_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  // The gap counter starts at 1 on release, so it needs at least two steps,
  // and a line needs a non-empty range below the abort length.
  if (GAP_CYCLES < 2) begin : g_bad_gap
    $error("morse_press_classifier: GAP_CYCLES must be at least 2");
  end
  if (DOT_MAX_CYCLES >= ABORT_CYCLES) begin : g_bad_dot
    $error("morse_press_classifier: DOT_MAX_CYCLES must be below ABORT_CYCLES");
  end

  logic               key;
  logic               key_d;
  logic [PRESS_W-1:0] press_cnt;
  morse_sym_e         press_sym;

  press_state_e       state;
  press_state_e       state_n;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_cnt_n;
  logic               sym_seen;
  logic               sym_seen_n;
  logic               dot_n;
  logic               line_n;
  logic               gap_pulse_n;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clock      (clock),
    .reset      (reset),
    .user_input (user_input),
    .key        (key)
  );

  // The conditioned key level is already a flop output; it drives the LED.
  assign pressing = key;

  // Press length: load 1 on the rising cycle, count while held, saturate
  // at the abort length so an endless press cannot wrap into a dot.
  // NOTE: clocked state is always assigned with <= so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_d     <= 1'b0;
      press_cnt <= '0;
    end else begin
      key_d <= key;
      if (key && !key_d) begin
        press_cnt <= PRESS_W'(1);
      end else if (key && (press_cnt != PRESS_MAX)) begin
        press_cnt <= press_cnt + 1'b1;
      end
    end
  end

  assign press_sym = classify_press(32'(press_cnt), DOT_MAX_CYCLES, ABORT_CYCLES);

  // Next-state and strobe decode for the press/gap sequencer.
  // NOTE: every variable gets a default first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    gap_cnt_n   = gap_cnt;
    sym_seen_n  = sym_seen;
    dot_n       = 1'b0;
    line_n      = 1'b0;
    gap_pulse_n = 1'b0;

    case (state)
      IDLE: begin
        if (key) begin
          state_n = PRESS;
        end
      end

      PRESS: begin
        if (!key) begin
          // The release cycle is the first released cycle of the gap.
          gap_cnt_n = GAP_W'(1);
          case (press_sym)
            MORSE_DOT: begin
              dot_n      = 1'b1;
              sym_seen_n = 1'b1;
              state_n    = GAP;
            end
            MORSE_LINE: begin
              line_n     = 1'b1;
              sym_seen_n = 1'b1;
              state_n    = GAP;
            end
            default: begin
              state_n = GAP_ABORT;
            end
          endcase
        end
      end

      GAP, GAP_ABORT: begin
        if (key) begin
          state_n = PRESS;
        end else if (gap_cnt == GAP_LAST) begin
          // After a discarded press the letter only ends with a strobe if
          // it already holds a valid symbol.
          state_n = IDLE;
          if ((state == GAP) || sym_seen) begin
            gap_pulse_n = 1'b1;
            sym_seen_n  = 1'b0;
          end
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, gap counter, per-letter flag and registered strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      sym_seen <= 1'b0;
      ld_dot   <= 1'b0;
      ld_line  <= 1'b0;
      ld_gap   <= 1'b0;
    end else begin
      state    <= state_n;
      gap_cnt  <= gap_cnt_n;
      sym_seen <= sym_seen_n;
      ld_dot   <= dot_n;
      ld_line  <= line_n;
      ld_gap   <= gap_pulse_n;
    end
  end

endmodule : morse_press_classifier
